// File: rtl/entity_pkg.sv
// Shared types and sizes for the entity scheduler slice.
//   NUM_ENTITIES          : number of slots in the entity register file
//   ENT_ID_W/ENT_X_W/ENT_Y_W : field widths of one entity record
//   entity_t              : packed {id, x, y} record
//   sched_state_t         : scheduler FSM states
package entity_pkg;

  localparam int unsigned NUM_ENTITIES = 4;
  localparam int unsigned ENT_ID_W     = 2;
  localparam int unsigned ENT_X_W      = 9;
  localparam int unsigned ENT_Y_W      = 9;

  typedef struct packed {
    logic [ENT_ID_W-1:0] id;
    logic [ENT_X_W-1:0]  x;
    logic [ENT_Y_W-1:0]  y;
  } entity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DONE,
    ST_UPDATE,
    ST_FRAME_END
  } sched_state_t;

endpackage

// File: rtl/entity_scheduler_if.sv
// Bus bundle between the scheduler, the entity register file, the sprite
// engine and the game-logic update requester.
//   master : scheduler side (drives file address/enables/write data, DRAW_*, UPD_ACK)
//   slave  : environment side (drives file read data, DRAW_DONE, UPD_*)
interface entity_scheduler_if #(
  parameter int unsigned ADDR_W = 2
);

  // entity register file
  logic [ADDR_W-1:0]                ENT_ADDRESS;
  logic                             ENT_RE;
  logic                             ENT_WE;
  logic [entity_pkg::ENT_ID_W-1:0]  ENT_SPRITE_ID;
  logic [entity_pkg::ENT_X_W-1:0]   ENT_X;
  logic [entity_pkg::ENT_Y_W-1:0]   ENT_Y;
  logic [entity_pkg::ENT_ID_W-1:0]  ENT_SPRITE_ID_W;
  logic [entity_pkg::ENT_X_W-1:0]   ENT_X_W;
  logic [entity_pkg::ENT_Y_W-1:0]   ENT_Y_W;

  // sprite engine handshake
  logic                             DRAW_START;
  logic [entity_pkg::ENT_ID_W-1:0]  DRAW_SPRITE_ID;
  logic [entity_pkg::ENT_X_W-1:0]   DRAW_X;
  logic [entity_pkg::ENT_Y_W-1:0]   DRAW_Y;
  logic                             DRAW_DONE;

  // game-logic update request
  logic                             UPD_REQ;
  logic [ADDR_W-1:0]                UPD_ADDR;
  logic [entity_pkg::ENT_ID_W-1:0]  UPD_SPRITE_ID;
  logic [entity_pkg::ENT_X_W-1:0]   UPD_X;
  logic [entity_pkg::ENT_Y_W-1:0]   UPD_Y;
  logic                             UPD_ACK;

  modport master (
    output ENT_ADDRESS, ENT_RE, ENT_WE, ENT_SPRITE_ID_W, ENT_X_W, ENT_Y_W,
    output DRAW_START, DRAW_SPRITE_ID, DRAW_X, DRAW_Y, UPD_ACK,
    input  ENT_SPRITE_ID, ENT_X, ENT_Y, DRAW_DONE,
    input  UPD_REQ, UPD_ADDR, UPD_SPRITE_ID, UPD_X, UPD_Y
  );

  modport slave (
    input  ENT_ADDRESS, ENT_RE, ENT_WE, ENT_SPRITE_ID_W, ENT_X_W, ENT_Y_W,
    input  DRAW_START, DRAW_SPRITE_ID, DRAW_X, DRAW_Y, UPD_ACK,
    output ENT_SPRITE_ID, ENT_X, ENT_Y, DRAW_DONE,
    output UPD_REQ, UPD_ADDR, UPD_SPRITE_ID, UPD_X, UPD_Y
  );

endinterface

// File: rtl/entity_scheduler_watchdog.sv
// draw_watchdog: counts cycles spent waiting for the sprite engine.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : restart the count at zero
//   en_i         : count this cycle (holds once expired)
//   expire_c_o   : count has reached DONE_TIMEOUT-1 (decoded from the register)
module draw_watchdog #(
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_c_o = (cnt_q == CNT_W'(DONE_TIMEOUT - 1));

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/entity_scheduler.sv
// Frame-level sequencer for the entity register file.
// On FRAME_START it walks slots 0..N-1 (N = min(STOP_ADDRESS, NUM_ENTITIES)),
// reads each one, registers it and hands it to the sprite engine with a
// DRAW_START/DRAW_DONE handshake. Between frames it forwards game-logic update
// requests into the file's single write port.
//   CLOCK_50, RESET_H : clock, synchronous active-high reset
//   FRAME_START       : one-cycle frame pulse
//   STOP_ADDRESS      : slot count for this frame
//   bus               : entity file / sprite engine / update bundle (master)
//   FRAME_DONE        : one-cycle pulse after the last slot
//   BUSY              : scheduler not idle
//   OVERRUN           : sticky, FRAME_START seen while not idle
//   TIMEOUT_ERR       : sticky, a DRAW_DONE wait timed out
module entity_scheduler #(
  parameter int unsigned NUM_ENTITIES = entity_pkg::NUM_ENTITIES,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET_H,
  input  logic                       FRAME_START,
  input  logic [2:0]                 STOP_ADDRESS,
  entity_scheduler_if.master         bus,
  output logic                       FRAME_DONE,
  output logic                       BUSY,
  output logic                       OVERRUN,
  output logic                       TIMEOUT_ERR
);

  import entity_pkg::*;

  // one extra bit so idx can reach N == NUM_ENTITIES without wrapping
  localparam int unsigned IDX_W = ADDR_W + 1;

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  n_q, n_d, n_eff;
  entity_t           draw_q, draw_d;
  entity_t           wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              draw_start_q, draw_start_d;
  logic              ent_re_q, ent_re_d;
  logic              ent_we_q, ent_we_d;
  logic              upd_ack_q, upd_ack_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              tmo_q, tmo_d;
  logic              wd_expire;
  logic              done_seen;

  // clamp requested slot count to the file size
  always_comb begin
    if (32'(STOP_ADDRESS) > NUM_ENTITIES) begin
      n_eff = IDX_W'(NUM_ENTITIES);
    end else begin
      n_eff = IDX_W'(STOP_ADDRESS);
    end
  end

  draw_watchdog #(
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) u_watchdog (
    .clk_i      (CLOCK_50),
    .rst_i      (RESET_H),
    .clr_i      (state_q == ST_FETCH),
    .en_i       (state_q == ST_WAIT_DONE),
    .expire_c_o (wd_expire)
  );

  // DRAW_DONE is not accepted in the DRAW_START cycle
  assign done_seen = bus.DRAW_DONE && !draw_start_q;

  // next state and next register values for every output
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    tmo_d     = tmo_q;
    overrun_d = overrun_q | (FRAME_START && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (FRAME_START) begin
          // N is latched so a mid-frame STOP_ADDRESS change cannot skip the end check
          n_d   = n_eff;
          idx_d = '0;
          state_d = (n_eff != '0) ? ST_FETCH : ST_FRAME_END;
        end else if (bus.UPD_REQ) begin
          state_d = ST_UPDATE;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_seen || wd_expire) begin
          idx_d = idx_q + IDX_W'(1);
          if (!done_seen) begin
            tmo_d = 1'b1;
          end
          state_d = (idx_d == n_q) ? ST_FRAME_END : ST_FETCH;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      ST_FRAME_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ent_re_d     = (state_d == ST_FETCH);
    ent_we_d     = (state_d == ST_UPDATE);
    upd_ack_d    = (state_d == ST_UPDATE);
    busy_d       = (state_d != ST_IDLE);
    draw_start_d = (state_q == ST_FETCH);
    frame_done_d = (state_q == ST_FRAME_END);

    addr_d = '0;
    wr_d   = '0;
    if (state_d == ST_FETCH) begin
      addr_d = idx_d[ADDR_W-1:0];
    end else if (state_d == ST_UPDATE) begin
      addr_d = bus.UPD_ADDR;
      wr_d   = {bus.UPD_SPRITE_ID, bus.UPD_X, bus.UPD_Y};
    end

    // file read data is valid during FETCH; hold it until the next fetch
    draw_d = draw_q;
    if (state_q == ST_FETCH) begin
      draw_d = {bus.ENT_SPRITE_ID, bus.ENT_X, bus.ENT_Y};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_H) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      draw_q       <= '0;
      wr_q         <= '0;
      addr_q       <= '0;
      draw_start_q <= 1'b0;
      ent_re_q     <= 1'b0;
      ent_we_q     <= 1'b0;
      upd_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      draw_q       <= draw_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      draw_start_q <= draw_start_d;
      ent_re_q     <= ent_re_d;
      ent_we_q     <= ent_we_d;
      upd_ack_q    <= upd_ack_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.ENT_ADDRESS     = addr_q;
  assign bus.ENT_RE          = ent_re_q;
  assign bus.ENT_WE          = ent_we_q;
  assign bus.ENT_SPRITE_ID_W = wr_q.id;
  assign bus.ENT_X_W         = wr_q.x;
  assign bus.ENT_Y_W         = wr_q.y;
  assign bus.DRAW_START      = draw_start_q;
  assign bus.DRAW_SPRITE_ID  = draw_q.id;
  assign bus.DRAW_X          = draw_q.x;
  assign bus.DRAW_Y          = draw_q.y;
  assign bus.UPD_ACK         = upd_ack_q;
  assign FRAME_DONE          = frame_done_q;
  assign BUSY                = busy_q;
  assign OVERRUN             = overrun_q;
  assign TIMEOUT_ERR         = tmo_q;

endmodule

// File: tb/tb_entity_scheduler.sv
// Directed bench for entity_scheduler: models the entity file and a sprite
// engine that answers DRAW_DONE 10 cycles after each DRAW_START.
module tb_entity_scheduler;

  import entity_pkg::*;

  localparam int unsigned ADDR_W = 2;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_H;
  logic       FRAME_START;
  logic [2:0] STOP_ADDRESS;
  logic       FRAME_DONE;
  logic       BUSY;
  logic       OVERRUN;
  logic       TIMEOUT_ERR;

  entity_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  entity_scheduler #(
    .NUM_ENTITIES (4),
    .ADDR_W       (ADDR_W),
    .DONE_TIMEOUT (16)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_H      (RESET_H),
    .FRAME_START  (FRAME_START),
    .STOP_ADDRESS (STOP_ADDRESS),
    .bus          (bus),
    .FRAME_DONE   (FRAME_DONE),
    .BUSY         (BUSY),
    .OVERRUN      (OVERRUN),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // entity file model: reset contents, combinational read
  entity_t mem [4];
  always @(posedge CLOCK_50) begin
    if (RESET_H) begin
      mem[0] <= {2'd0, 9'd32,  9'd32};
      mem[1] <= {2'd1, 9'd256, 9'd32};
      mem[2] <= {2'd1, 9'd32,  9'd192};
      mem[3] <= {2'd2, 9'd256, 9'd192};
    end else if (bus.ENT_WE) begin
      mem[bus.ENT_ADDRESS] <= {bus.ENT_SPRITE_ID_W, bus.ENT_X_W, bus.ENT_Y_W};
    end
  end
  assign bus.ENT_SPRITE_ID = mem[bus.ENT_ADDRESS].id;
  assign bus.ENT_X         = mem[bus.ENT_ADDRESS].x;
  assign bus.ENT_Y         = mem[bus.ENT_ADDRESS].y;

  logic any_out;
  assign any_out = |{FRAME_DONE, BUSY, OVERRUN, TIMEOUT_ERR, bus.ENT_RE, bus.ENT_WE,
                     bus.UPD_ACK, bus.DRAW_START, bus.ENT_ADDRESS, bus.ENT_SPRITE_ID_W,
                     bus.ENT_X_W, bus.ENT_Y_W, bus.DRAW_SPRITE_ID, bus.DRAW_X, bus.DRAW_Y};

  // monitor + sprite engine
  entity_t log_e [64];
  int      log_c [64];
  int dcount = 0, fd_cnt = 0, fd_cyc = 0, ack_cnt = 0, ack_cyc = 0;
  int we_cnt = 0, we_cyc = 0, both_cnt = 0, re_cnt = 0, overlap = 0;
  int pend = 0;
  int withhold = -1;

  always @(negedge CLOCK_50) begin
    bus.DRAW_DONE = 1'b0;
    if (RESET_H) begin
      pend = 0;
    end else if (bus.DRAW_START) begin
      if (dcount < 64) begin
        log_e[dcount] = {bus.DRAW_SPRITE_ID, bus.DRAW_X, bus.DRAW_Y};
        log_c[dcount] = cyc;
      end
      pend = (dcount == withhold) ? 0 : 10;
      dcount++;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) bus.DRAW_DONE = 1'b1;
    end
    if (FRAME_DONE) begin fd_cnt++; fd_cyc = cyc; end
    if (bus.UPD_ACK) begin ack_cnt++; ack_cyc = cyc; end
    if (bus.ENT_WE) begin we_cnt++; we_cyc = cyc; end
    if (bus.UPD_ACK && bus.ENT_WE) both_cnt++;
    if (bus.ENT_RE) re_cnt++;
    if (bus.ENT_RE && bus.ENT_WE) overlap++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic start_frame(input logic [2:0] stop, output int t0);
    STOP_ADDRESS = stop;
    FRAME_START  = 1'b1;
    t0 = cyc;
    @(negedge CLOCK_50);
    FRAME_START = 1'b0;
  endtask

  task automatic wait_fd(input int f0);
    int n = 0;
    while (fd_cnt == f0 && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (fd_cnt == f0) chk("frame_done_wait", 0, 1);
    @(negedge CLOCK_50);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!bus.UPD_ACK && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!bus.UPD_ACK) chk("ack_wait", 0, 1);
    bus.UPD_REQ = 1'b0;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic wait_draws(input int target);
    int n = 0;
    while (dcount < target && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (dcount < target) chk("draw_wait", 0, 1);
  endtask

  entity_t rst_tab [4];
  int t0, d0, f0, a0, w0, b0, r0;

  initial begin
    rst_tab[0] = {2'd0, 9'd32,  9'd32};
    rst_tab[1] = {2'd1, 9'd256, 9'd32};
    rst_tab[2] = {2'd1, 9'd32,  9'd192};
    rst_tab[3] = {2'd2, 9'd256, 9'd192};
    RESET_H = 1'b1; FRAME_START = 1'b0; STOP_ADDRESS = 3'd4;
    bus.UPD_REQ = 1'b0; bus.UPD_ADDR = '0;
    bus.UPD_SPRITE_ID = '0; bus.UPD_X = '0; bus.UPD_Y = '0;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_outs", 32'(any_out), 0);
    RESET_H = 1'b0;
    @(negedge CLOCK_50);

    // full frame from reset contents
    d0 = dcount; f0 = fd_cnt; r0 = re_cnt;
    start_frame(3'd4, t0);
    wait_fd(f0);
    chk("f1_draws", 32'(dcount - d0), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("f1_slot%0d", i), 32'(log_e[d0+i]), 32'(rst_tab[i]));
    chk("f1_first_latency", 32'(log_c[d0] - t0), 2);
    chk("f1_done_count", 32'(fd_cnt - f0), 1);
    chk("f1_done_latency", 32'(fd_cyc - t0), 50);
    chk("f1_busy_after", 32'(BUSY), 0);
    chk("f1_reads", 32'(re_cnt - r0), 4);

    // update in idle
    a0 = ack_cnt; w0 = we_cnt; b0 = both_cnt;
    bus.UPD_ADDR = 2'd2; bus.UPD_SPRITE_ID = 2'd3; bus.UPD_X = 9'd100; bus.UPD_Y = 9'd50;
    bus.UPD_REQ = 1'b1;
    @(negedge CLOCK_50);
    wait_ack();
    chk("upd_ack_count", 32'(ack_cnt - a0), 1);
    chk("upd_we_count", 32'(we_cnt - w0), 1);
    chk("upd_ack_with_we", 32'(both_cnt - b0), 1);
    d0 = dcount; f0 = fd_cnt;
    start_frame(3'd4, t0);
    wait_fd(f0);
    chk("f2_slot2", 32'(log_e[d0+2]), 32'({2'd3, 9'd100, 9'd50}));
    chk("f2_slot0", 32'(log_e[d0]), 32'(rst_tab[0]));

    // frame start and update in the same cycle: frame wins
    d0 = dcount; f0 = fd_cnt; w0 = we_cnt;
    bus.UPD_ADDR = 2'd0; bus.UPD_SPRITE_ID = 2'd2; bus.UPD_X = 9'd7; bus.UPD_Y = 9'd9;
    bus.UPD_REQ = 1'b1;
    start_frame(3'd4, t0);
    wait_ack();
    chk("f3_done_count", 32'(fd_cnt - f0), 1);
    chk("f3_draws", 32'(dcount - d0), 4);
    chk("f3_ack_after_done", 32'(ack_cyc - fd_cyc), 1);
    chk("f3_we_count", 32'(we_cnt - w0), 1);
    chk("f3_we_after_done", 32'(we_cyc - fd_cyc), 1);

    // stop count 0 and clamping of 7
    d0 = dcount; f0 = fd_cnt;
    start_frame(3'd0, t0);
    wait_fd(f0);
    chk("s0_done_latency", 32'(fd_cyc - t0), 2);
    chk("s0_draws", 32'(dcount - d0), 0);
    d0 = dcount; f0 = fd_cnt;
    start_frame(3'd7, t0);
    wait_fd(f0);
    chk("s7_draws", 32'(dcount - d0), 4);
    chk("s7_slot0_updated", 32'(log_e[d0]), 32'({2'd2, 9'd7, 9'd9}));

    // DRAW_DONE withheld on slot 1
    chk("tmo_before", 32'(TIMEOUT_ERR), 0);
    d0 = dcount; f0 = fd_cnt;
    withhold = dcount + 1;
    start_frame(3'd4, t0);
    wait_fd(f0);
    withhold = -1;
    chk("tmo_draws", 32'(dcount - d0), 4);
    chk("tmo_gap", 32'(log_c[d0+2] - log_c[d0+1]), 17);
    chk("tmo_flag", 32'(TIMEOUT_ERR), 1);
    chk("tmo_slot2", 32'(log_e[d0+2]), 32'({2'd3, 9'd100, 9'd50}));
    chk("tmo_slot3", 32'(log_e[d0+3]), 32'(rst_tab[3]));

    // FRAME_START while waiting on the sprite engine
    chk("ovr_before", 32'(OVERRUN), 0);
    d0 = dcount; f0 = fd_cnt;
    start_frame(3'd4, t0);
    wait_draws(d0 + 1);
    @(negedge CLOCK_50);
    FRAME_START = 1'b1;
    @(negedge CLOCK_50);
    FRAME_START = 1'b0;
    wait_fd(f0);
    chk("ovr_flag", 32'(OVERRUN), 1);
    chk("ovr_draws", 32'(dcount - d0), 4);
    chk("ovr_done_count", 32'(fd_cnt - f0), 1);
    chk("ovr_done_latency", 32'(fd_cyc - t0), 50);

    // reset mid-frame
    d0 = dcount; f0 = fd_cnt;
    start_frame(3'd4, t0);
    wait_draws(d0 + 2);
    RESET_H = 1'b1;
    @(negedge CLOCK_50);
    RESET_H = 1'b0;
    chk("rst_outs", 32'(any_out), 0);
    repeat (80) @(negedge CLOCK_50);
    chk("rst_no_done", 32'(fd_cnt - f0), 0);
    chk("rst_draws", 32'(dcount - d0), 2);
    d0 = dcount; f0 = fd_cnt;
    start_frame(3'd4, t0);
    wait_fd(f0);
    chk("rst_slot2_reinit", 32'(log_e[d0+2]), 32'(rst_tab[2]));
    chk("rst_done_latency", 32'(fd_cyc - t0), 50);
    chk("re_we_overlap", 32'(overlap), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
